// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, types and latency clamp for the decode hazard scoreboard.
package scoreboard_pkg;

    localparam int NUM_REGS = 32;
    localparam int MAX_LAT  = 6;
    localparam int LAT_W    = $clog2(MAX_LAT + 1);
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef logic [LAT_W-1:0] lat_t;
    typedef logic [REG_W-1:0] reg_idx_t;

    function automatic lat_t sat_lat(input lat_t lat);
        return (int'(lat) > MAX_LAT) ? lat_t'(MAX_LAT) : lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage <-> scoreboard signals; decode is the master, scoreboard the slave.
interface hazard_scoreboard_if;
    import scoreboard_pkg::*;

    logic                Hold;
    logic                ID_valid;
    reg_idx_t            ID_rs;
    reg_idx_t            ID_rt;
    logic                ID_uses_rs;
    logic                ID_uses_rt;
    logic                ID_RegWrite;
    reg_idx_t            ID_WriteRegister;
    lat_t                ID_latency;
    logic                ID_stall;
    logic                ID_issue;
    logic [NUM_REGS-1:0] pending_mask;

    modport master (
        output Hold, ID_valid, ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
               ID_RegWrite, ID_WriteRegister, ID_latency,
        input  ID_stall, ID_issue, pending_mask
    );

    modport slave (
        input  Hold, ID_valid, ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
               ID_RegWrite, ID_WriteRegister, ID_latency,
        output ID_stall, ID_issue, pending_mask
    );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One per-register countdown: decrements to zero, loads by max rule, freezes on hold.
module scoreboard_entry
    import scoreboard_pkg::*;
(
    input  logic Clk,
    input  logic Rst_n,
    input  logic hold,
    input  logic load,
    input  lat_t lat,
    output lat_t cnt
);

    lat_t dec;

    assign dec = (cnt == '0) ? '0 : cnt - lat_t'(1);

    // A younger, shorter write must never shorten an older pending count.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (load && (lat > dec)) ? lat : dec;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode hazard scoreboard: per-register countdowns, stall/issue, pending mask.
// Optional stall statistics counter enabled by SCOREBOARD_STATS_EN.
module hazard_scoreboard
    import scoreboard_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst_n,
    hazard_scoreboard_if.slave  sb
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    logic [NUM_REGS-1:0] pending;
    lat_t                lat_sat;
    logic                wr_en;

    assign lat_sat = sat_lat(sb.ID_latency);

    // Register 0 is hard-wired zero and never tracked.
    assign pending[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        lat_t cnt_r;

        scoreboard_entry u_entry (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .hold  (sb.Hold),
            .load  (wr_en && (sb.ID_WriteRegister == reg_idx_t'(r))),
            .lat   (lat_sat),
            .cnt   (cnt_r)
        );

        assign pending[r] = (cnt_r != '0);
    end

    // Stall looks at the pre-edge counters, so a self-dependent instruction waits only on older writers.
    assign sb.ID_stall     = sb.ID_valid &&
                             ((sb.ID_uses_rs && pending[sb.ID_rs]) ||
                              (sb.ID_uses_rt && pending[sb.ID_rt]));
    assign sb.ID_issue     = sb.ID_valid && !sb.ID_stall && !sb.Hold;
    assign wr_en           = sb.ID_issue && sb.ID_RegWrite;
    assign sb.pending_mask = pending;

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cycles <= '0;
        end else if (sb.ID_stall && !sb.Hold && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (optionally with SCOREBOARD_STATS_EN).
module tb_hazard_scoreboard;
    import scoreboard_pkg::*;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   errors;

    hazard_scoreboard_if sb ();

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    hazard_scoreboard dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .sb    (sb)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        hold;
        logic        valid;
        logic [4:0]  rs;
        logic        urs;
        logic [4:0]  rt;
        logic        urt;
        logic        rw;
        logic [4:0]  wd;
        logic [2:0]  lat;
        logic        e_stall;
        logic        e_issue;
        logic [31:0] e_mask;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic hold, input logic valid,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic rw, input logic [4:0] wd, input logic [2:0] lat,
                       input logic e_stall, input logic e_issue, input logic [31:0] e_mask);
        vec_t v;
        v.hold = hold; v.valid = valid; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
        v.rw = rw; v.wd = wd; v.lat = lat;
        v.e_stall = e_stall; v.e_issue = e_issue; v.e_mask = e_mask;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic hold, input logic valid,
                         input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic rw, input logic [4:0] wd, input logic [2:0] lat);
        sb.Hold = hold; sb.ID_valid = valid;
        sb.ID_rs = rs; sb.ID_uses_rs = urs; sb.ID_rt = rt; sb.ID_uses_rt = urt;
        sb.ID_RegWrite = rw; sb.ID_WriteRegister = wd; sb.ID_latency = lat;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] bit_of(input int r);
        logic [31:0] m;
        m = 32'h1 << r;
        return m;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        // Reset with a reader of $5 presented for two edges.
        Rst_n = 1'b0;
        drive(0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 3'd0);
        tick();
        tick();
        Rst_n = 1'b1;
        #1;
        check("reset_mask", sb.pending_mask, 32'h0);
        check("reset_stall", {31'b0, sb.ID_stall}, 32'h0);
`ifdef SCOREBOARD_STATS_EN
        check("reset_stats", stall_cycles, 32'h0);
`endif

        //  hold valid rs urs rt urt rw wd lat   stall issue mask
        // RAW on $8, latency 3
        add(0, 1,  0, 0,  0, 0,  1,  8, 3,   0, 1, 32'h0);
        for (int i = 0; i < 3; i++) add(0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, bit_of(8));
        add(0, 1,  8, 1,  0, 0,  0,  0, 0,   0, 1, 32'h0);
        // $0 is never tracked
        add(0, 1,  0, 0,  0, 0,  1,  0, 5,   0, 1, 32'h0);
        add(0, 1,  0, 1,  0, 1,  0,  0, 0,   0, 1, 32'h0);
        // Pending $9 with uses_rt=0
        add(0, 1,  0, 0,  0, 0,  1,  9, 2,   0, 1, 32'h0);
        add(0, 1,  0, 1,  9, 0,  0,  0, 0,   0, 1, bit_of(9));
        add(0, 0,  0, 0,  0, 0,  0,  0, 0,   0, 0, bit_of(9));
        add(0, 0,  0, 0,  0, 0,  0,  0, 0,   0, 0, 32'h0);
        // WAW on $4: L=6 then L=2, shorter write must not shorten the count
        add(0, 1,  0, 0,  0, 0,  1,  4, 6,   0, 1, 32'h0);
        add(0, 1,  0, 0,  0, 0,  1,  4, 2,   0, 1, bit_of(4));
        for (int i = 0; i < 5; i++) add(0, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, bit_of(4));
        add(0, 1,  4, 1,  0, 0,  0,  0, 0,   0, 1, 32'h0);
        // Hold for 4 cycles at cnt[10]=2
        add(0, 1,  0, 0,  0, 0,  1, 10, 4,   0, 1, 32'h0);
        add(0, 1,  0, 0, 10, 1,  0,  0, 0,   1, 0, bit_of(10));
        add(0, 1,  0, 0, 10, 1,  0,  0, 0,   1, 0, bit_of(10));
        for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 10, 1, 0, 0, 0, 1, 0, bit_of(10));
        add(0, 1,  0, 0, 10, 1,  0,  0, 0,   1, 0, bit_of(10));
        add(0, 1,  0, 0, 10, 1,  0,  0, 0,   1, 0, bit_of(10));
        add(0, 1,  0, 0, 10, 1,  0,  0, 0,   0, 1, 32'h0);
        // Hold blocks issue of an unstalled writer
        add(1, 1,  0, 0,  0, 0,  1,  5, 3,   0, 0, 32'h0);
        add(0, 0,  0, 0,  0, 0,  0,  0, 0,   0, 0, 32'h0);
        // Latency 7 saturates to 6
        add(0, 1,  0, 0,  0, 0,  1, 12, 7,   0, 1, 32'h0);
        for (int i = 0; i < 6; i++) add(0, 1, 12, 1, 0, 0, 0, 0, 0, 1, 0, bit_of(12));
        add(0, 1, 12, 1,  0, 0,  0,  0, 0,   0, 1, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].hold, vecs[i].valid, vecs[i].rs, vecs[i].urs, vecs[i].rt,
                  vecs[i].urt, vecs[i].rw, vecs[i].wd, vecs[i].lat);
            #1;
            check($sformatf("v%0d_stall", i), {31'b0, sb.ID_stall}, {31'b0, vecs[i].e_stall});
            check($sformatf("v%0d_issue", i), {31'b0, sb.ID_issue}, {31'b0, vecs[i].e_issue});
            check($sformatf("v%0d_mask", i), sb.pending_mask, vecs[i].e_mask);
            tick();
        end

`ifdef SCOREBOARD_STATS_EN
        // 3 (RAW) + 5 (WAW) + 4 (non-hold part of hold test) + 6 (saturation)
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("stats_total", stall_cycles, 32'd18);
`endif

        // Reset mid-countdown, with hold and a competing issue in the reset cycle
        drive(0, 1, 0, 0, 0, 0, 1, 5'd7, 3'd6);
        tick();
        drive(0, 1, 5'd7, 1, 0, 0, 0, 0, 0);
        #1;
        check("midcnt_mask", sb.pending_mask, bit_of(7));
        check("midcnt_stall", {31'b0, sb.ID_stall}, 32'h1);
        tick();
        Rst_n = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 1, 5'd6, 3'd3);
        tick();
        Rst_n = 1'b1;
        drive(0, 1, 5'd7, 1, 5'd6, 1, 0, 0, 0);
        #1;
        check("rst_mid_mask", sb.pending_mask, 32'h0);
        check("rst_mid_stall", {31'b0, sb.ID_stall}, 32'h0);
        check("rst_mid_issue", {31'b0, sb.ID_issue}, 32'h1);
`ifdef SCOREBOARD_STATS_EN
        check("rst_mid_stats", stall_cycles, 32'h0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
